uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter. Adds a write FIFO, configurable data width, parity mode and stop-bit count, and an internal 16x-oversampling baud divider. Connects to the existing uart_receiver via the serial line TxD. Interface semantics match the current transmitter.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2.
PARITY, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clock  in  1  system clock, 50 MHz (20 ns period).
reset  in  1  synchronous, active-low reset.
Tx_DATA  in  DATA_WIDTH  write data.
baud_select  in  3  rate select (table below).
Tx_WR  in  1  write strobe, one word per high cycle.
TX_EN  in  1  transmit enable.
TxD  out  1  serial line, idles high.
TX_BUSY  out  1  high while a frame is on the line.
TX_FULL  out  1  FIFO holds FIFO_DEPTH words.
TX_EMPTY  out  1  FIFO holds 0 words.
TX_OVF  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset is taken when reset = 0 at a clock edge; it is synchronous. State after reset:
  - TxD = 1, TX_BUSY = 0, TX_FULL = 0, TX_EMPTY = 1, TX_OVF = 0.
  - FIFO pointers and count = 0; FSM = IDLE; divider counters = 0.
  - Reset mid-frame aborts the frame. TxD is 1 on the cycle after the reset edge.
- Baud divider values (clock cycles per 16x tick), by baud_select:
  - 000 = 10417, 001 = 2604, 010 = 651, 011 = 326.
  - 100 = 163, 101 = 81, 110 = 54, 111 = 27.
  - One bit = 16 ticks = 16 x DIV clock cycles exactly.
  - baud_select is latched at frame start. Changes mid-frame take effect on the next frame.
- FIFO write:
  - Tx_WR = 1 and not full: push Tx_DATA. Count updates the next cycle.
  - Tx_WR = 1 and full, with no pop in the same cycle: word dropped, TX_OVF = 1 for one cycle.
  - Writes are accepted regardless of TX_EN.
  - Push and pop in the same cycle: the write is accepted even when full; count is unchanged.
- FIFO flags: TX_FULL = (count == FIFO_DEPTH), TX_EMPTY = (count == 0). Both are registered from count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If TX_EN = 1 and not empty: pop the head into the shift register, latch the divider, clear the tick and bit counters, go to START.
  - TxD falls on the cycle after the pop cycle.
- START: TxD = 0 for one bit, then go to DATA.
- DATA:
  - Send DATA_WIDTH bits, LSB first, one bit each.
  - Then go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY:
  - Even mode: TxD = XOR of the payload.
  - Odd mode: TxD = inverse of that XOR.
  - Duration is one bit.
- STOP: TxD = 1 for STOP_BITS bits.
- End of the STOP period:
  - If TX_EN = 1 and not empty: pop and enter START directly. There is no idle gap between frames.
  - Otherwise go to IDLE.
- TX_EN deasserted mid-frame: the current frame completes; no new frame starts.
- TX_BUSY = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Frame length in bits = 1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS. The 8E1 default is 11 bits.

Test Plan:
- Reset then single word. After reset, baud_select = 111, TX_EN = 1, write 8'b11011101 once.
  - TxD low exactly 432 cycles.
  - Data bits 1,0,1,1,1,0,1,1 at 432 cycles each.
  - Parity 0, stop 1; TX_BUSY high for 4752 cycles.
  - The same word, with no error flags, is received by uart_receiver.
- Odd parity. PARITY = 2, word 8'b00011010 → parity bit = 0 (XOR = 1, inverted). PARITY = 2, word 8'h00 → parity bit = 1.
- FIFO fill and overflow. TX_EN = 0, write 5 words with FIFO_DEPTH = 4.
  - TX_FULL = 1 after the 4th write.
  - TX_OVF pulses once on the 5th write; the 5th word never appears on TxD.
  - Then set TX_EN = 1: 4 frames go out back-to-back with no idle cycle between the stop bit and the next start bit.
  - TX_EMPTY = 1 at the first pop of the 4th word.
- Config sweep. DATA_WIDTH = 7, PARITY = 0, STOP_BITS = 2 at baud_select = 110: frame is 10 bits, each 864 cycles; TxD high for 1728 cycles at the end.
- baud_select change mid-frame. Switch 111 → 110 during DATA: the current frame keeps 432-cycle bits; the next frame uses 864-cycle bits.
- Reset mid-frame, and TX_EN drop.
  - Assert reset = 0 during DATA: next cycle TxD = 1, TX_BUSY = 0, TX_EMPTY = 1.
  - Separately, drop TX_EN during DATA: the frame completes and the remaining FIFO words stay queued.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, configurable frame format and a
// 16x-oversampling baud divider selected per frame by baud_select.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Tx_DATA,
    input  logic [2:0]            baud_select,
    input  logic                  Tx_WR,
    input  logic                  TX_EN,
    output logic                  TxD,
    output logic                  TX_BUSY,
    output logic                  TX_FULL,
    output logic                  TX_EMPTY,
    output logic                  TX_OVF
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic [13:0] divFor(input logic [2:0] sel);
        case (sel)
            3'd0:    divFor = 14'd10417;
            3'd1:    divFor = 14'd2604;
            3'd2:    divFor = 14'd651;
            3'd3:    divFor = 14'd326;
            3'd4:    divFor = 14'd163;
            3'd5:    divFor = 14'd81;
            3'd6:    divFor = 14'd54;
            default: divFor = 14'd27;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parBit_q, parBit_d;
    logic [2:0]              divSel_q, divSel_d;
    logic [13:0]             divCnt_q, divCnt_d;
    logic [3:0]              tickCnt_q, tickCnt_d;
    logic [3:0]              bitCnt_q, bitCnt_d;
    logic                    txd_q, txd_d;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wrPtr_q, rdPtr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    full_q, empty_q, ovf_q;

    logic                    push, pop, startFrame;
    logic                    divEnd, bitEnd;
    logic [DATA_WIDTH-1:0]   headWord;
    logic                    headPar;

    assign headWord = mem_q[rdPtr_q];
    assign headPar  = (PARITY == 2) ? ~(^headWord) : ^headWord;
    assign divEnd   = (divCnt_q == divFor(divSel_q) - 14'd1);
    assign bitEnd   = divEnd && (tickCnt_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parBit_d   = parBit_q;
        divSel_d   = divSel_q;
        divCnt_d   = divCnt_q;
        tickCnt_d  = tickCnt_q;
        bitCnt_d   = bitCnt_q;
        startFrame = 1'b0;

        if (state_q != S_IDLE) begin
            divCnt_d = divEnd ? 14'd0 : divCnt_q + 14'd1;
            if (divEnd) begin
                tickCnt_d = tickCnt_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (TX_EN && !empty_q) begin
                    startFrame = 1'b1;
                end
            end
            S_START: begin
                if (bitEnd) begin
                    state_d  = S_DATA;
                    bitCnt_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bitEnd) begin
                    shift_d = shift_q >> 1;
                    if (bitCnt_q == LAST_DATA) begin
                        bitCnt_d = 4'd0;
                        state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bitEnd) begin
                    state_d  = S_STOP;
                    bitCnt_d = 4'd0;
                end
            end
            S_STOP: begin
                if (bitEnd) begin
                    if (bitCnt_q == LAST_STOP) begin
                        if (TX_EN && !empty_q) begin
                            startFrame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new frame may start from IDLE or straight out of the last stop bit.
        if (startFrame) begin
            state_d   = S_START;
            shift_d   = headWord;
            parBit_d  = headPar;
            divSel_d  = baud_select;
            divCnt_d  = 14'd0;
            tickCnt_d = 4'd0;
            bitCnt_d  = 4'd0;
        end

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parBit_d;
            default:  txd_d = 1'b1;
        endcase
    end

    assign pop  = startFrame;
    assign push = Tx_WR && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= Tx_DATA;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            parBit_q  <= 1'b0;
            divSel_q  <= 3'd0;
            divCnt_q  <= 14'd0;
            tickCnt_q <= 4'd0;
            bitCnt_q  <= 4'd0;
            txd_q     <= 1'b1;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parBit_q  <= parBit_d;
            divSel_q  <= divSel_d;
            divCnt_q  <= divCnt_d;
            tickCnt_q <= tickCnt_d;
            bitCnt_q  <= bitCnt_d;
            txd_q     <= txd_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q   <= count_d;
            full_q    <= (count_d == DEPTH_C);
            empty_q   <= (count_d == '0);
            ovf_q     <= Tx_WR && full_q && !pop;
        end
    end

    assign TxD      = txd_q;
    assign TX_BUSY  = (state_q != S_IDLE);
    assign TX_FULL  = full_q;
    assign TX_EMPTY = empty_q;
    assign TX_OVF   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a default 8E1 instance, an odd-parity
// instance and a 7N2 instance share one clock and reset.
module tb_uart_tx_fifo;

    typedef struct packed {
        logic       rstN;
        logic       wr;
        logic [7:0] data;
        logic       en;
        logic       expTxd;
        logic       expBusy;
        logic       expFull;
        logic       expEmpty;
        logic       expOvf;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetN;
    logic [7:0] wrData;
    logic [2:0] baudSel;
    logic       wrEn, txEn;
    logic       txd, busy, full, empty, ovf;

    logic [7:0] oData;
    logic [2:0] oBaud;
    logic       oWr, oEn;
    logic       oTxd, oBusy, oFull, oEmpty, oOvf;

    logic [6:0] cData;
    logic [2:0] cBaud;
    logic       cWr, cEn;
    logic       cTxd, cBusy, cFull, cEmpty, cOvf;

    int vecCount  = 0;
    int missCount = 0;
    vec_t vecs [7];

    always #10 clock = ~clock;

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut (
        .clock(clock), .reset(resetN), .Tx_DATA(wrData), .baud_select(baudSel),
        .Tx_WR(wrEn), .TX_EN(txEn), .TxD(txd), .TX_BUSY(busy),
        .TX_FULL(full), .TX_EMPTY(empty), .TX_OVF(ovf)
    );

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dutOdd (
        .clock(clock), .reset(resetN), .Tx_DATA(oData), .baud_select(oBaud),
        .Tx_WR(oWr), .TX_EN(oEn), .TxD(oTxd), .TX_BUSY(oBusy),
        .TX_FULL(oFull), .TX_EMPTY(oEmpty), .TX_OVF(oOvf)
    );

    uart_tx_fifo #(.DATA_WIDTH(7), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) dutCfg (
        .clock(clock), .reset(resetN), .Tx_DATA(cData), .baud_select(cBaud),
        .Tx_WR(cWr), .TX_EN(cEn), .TxD(cTxd), .TX_BUSY(cBusy),
        .TX_FULL(cFull), .TX_EMPTY(cEmpty), .TX_OVF(cOvf)
    );

    function automatic logic lineOf(input int which);
        return (which == 0) ? txd : (which == 1) ? oTxd : cTxd;
    endfunction

    function automatic logic busyOf(input int which);
        return (which == 0) ? busy : (which == 1) ? oBusy : cBusy;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        resetN = v.rstN;
        wrEn   = v.wr;
        wrData = v.data;
        txEn   = v.en;
        @(negedge clock);
        checkOutput($sformatf("vec%0d TxD", idx), txd, v.expTxd);
        checkOutput($sformatf("vec%0d TX_BUSY", idx), busy, v.expBusy);
        checkOutput($sformatf("vec%0d TX_FULL", idx), full, v.expFull);
        checkOutput($sformatf("vec%0d TX_EMPTY", idx), empty, v.expEmpty);
        checkOutput($sformatf("vec%0d TX_OVF", idx), ovf, v.expOvf);
    endtask

    task automatic waitStart(input int which, input int bound, input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < bound && !found; k++) begin
            @(negedge clock);
            if (lineOf(which) === 1'b0) found = 1'b1;
        end
        checkOutput(name, found, 1);
    endtask

    // bits[0] is the start bit; each bit must hold its level for bitLen samples.
    task automatic checkFrame(input int which, input string tag, input logic [15:0] bits,
                              input int nbits, input int bitLen, input bit aligned);
        int good;
        int busyCnt;
        busyCnt = 0;
        for (int b = 0; b < nbits; b++) begin
            good = 0;
            for (int c = 0; c < bitLen; c++) begin
                if (!(aligned && b == 0 && c == 0)) @(negedge clock);
                if (lineOf(which) === bits[b]) good++;
                if (busyOf(which) === 1'b1) busyCnt++;
            end
            checkOutput($sformatf("%s bit%0d cycles at %0b", tag, b, bits[b]), good, bitLen);
        end
        checkOutput($sformatf("%s busy cycles", tag), busyCnt, nbits * bitLen);
    endtask

    initial begin
        repeat (100000) @(posedge clock);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        resetN = 1'b0; wrEn = 1'b0; wrData = 8'h00; txEn = 1'b0; baudSel = 3'b111;
        oWr = 1'b0; oData = 8'h00; oEn = 1'b0; oBaud = 3'b111;
        cWr = 1'b0; cData = 7'h00; cEn = 1'b0; cBaud = 3'b110;

        //            rstN  wr    data   en    txd   busy  full  empty ovf
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        $display("[TB] draining four queued words back-to-back");
        txEn = 1'b1;
        waitStart(0, 8, "drain start");
        checkFrame(0, "q0", {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 432, 1'b1);
        checkFrame(0, "q1", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 432, 1'b0);
        checkFrame(0, "q2", {1'b1, 1'b1, 8'h01, 1'b0}, 11, 432, 1'b0);
        @(negedge clock);
        checkOutput("q3 start txd", txd, 0);
        checkOutput("q3 pop empty", empty, 1);
        checkFrame(0, "q3", {1'b1, 1'b0, 8'hF0, 1'b0}, 11, 432, 1'b1);
        @(negedge clock);
        checkOutput("drain busy", busy, 0);
        hi = 0;
        repeat (600) begin
            @(negedge clock);
            if (txd === 1'b1) hi++;
        end
        checkOutput("dropped word not sent", hi, 600);

        $display("[TB] reset then single word 8'hDD");
        resetN = 1'b0;
        txEn = 1'b1;
        @(negedge clock);
        resetN = 1'b1; wrEn = 1'b1; wrData = 8'hDD;
        @(negedge clock);
        wrEn = 1'b0;
        checkOutput("single pre-pop txd", txd, 1);
        checkOutput("single pre-pop empty", empty, 0);
        @(negedge clock);
        checkOutput("single txd falls", txd, 0);
        checkOutput("single empty after pop", empty, 1);
        checkFrame(0, "dd", {1'b1, 1'b0, 8'hDD, 1'b0}, 11, 432, 1'b1);
        @(negedge clock);
        checkOutput("single busy after frame", busy, 0);
        checkOutput("single txd idle", txd, 1);

        $display("[TB] baud change mid-frame and TX_EN drop");
        txEn = 1'b0;
        foreach (vecs[i]) if (i < 3) begin
            wrEn = 1'b1;
            wrData = (i == 0) ? 8'h5A : (i == 1) ? 8'hC3 : 8'h96;
            @(negedge clock);
        end
        wrEn = 1'b0;
        txEn = 1'b1;
        fork
            begin
                waitStart(0, 8, "bc start");
                checkFrame(0, "bc0", {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 432, 1'b1);
                checkFrame(0, "bc1", {1'b1, 1'b0, 8'hC3, 1'b0}, 11, 864, 1'b0);
            end
            begin
                repeat (1300) @(negedge clock);
                baudSel = 3'b110;
                repeat (7300) @(negedge clock);
                txEn = 1'b0;
            end
        join
        @(negedge clock);
        checkOutput("en drop busy", busy, 0);
        checkOutput("en drop word queued", empty, 0);
        hi = 0;
        repeat (100) begin
            @(negedge clock);
            if (txd === 1'b1 && busy === 1'b0) hi++;
        end
        checkOutput("en drop stays idle", hi, 100);

        $display("[TB] reset mid-frame");
        txEn = 1'b1;
        waitStart(0, 8, "rst start");
        repeat (1000) @(negedge clock);
        checkOutput("pre-reset txd", txd, 0);
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("reset txd", txd, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset empty", empty, 1);
        checkOutput("reset full", full, 0);
        resetN = 1'b1;
        txEn = 1'b0;

        $display("[TB] odd parity instance");
        oWr = 1'b1; oData = 8'h1A;
        @(negedge clock);
        oData = 8'h00;
        @(negedge clock);
        oWr = 1'b0; oEn = 1'b1;
        waitStart(1, 8, "odd start");
        checkFrame(1, "odd1A", {1'b1, 1'b0, 8'h1A, 1'b0}, 11, 432, 1'b1);
        checkFrame(1, "odd00", {1'b1, 1'b1, 8'h00, 1'b0}, 11, 432, 1'b0);
        @(negedge clock);
        checkOutput("odd busy after", oBusy, 0);

        $display("[TB] 7N2 instance at baud_select 110");
        cWr = 1'b1; cData = 7'h55; cEn = 1'b1;
        @(negedge clock);
        cWr = 1'b0;
        waitStart(2, 8, "cfg start");
        checkFrame(2, "cfg", {1'b1, 1'b1, 7'h55, 1'b0}, 10, 864, 1'b1);
        @(negedge clock);
        checkOutput("cfg busy after", cBusy, 0);
        checkOutput("cfg txd idle", cTxd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
